// File: rtl/seq_pattern_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : seq_pattern_pkg
// Purpose  : Shared types and helpers for the programmable step-sequence
//            generator. Holds the FSM state encoding and the function that
//            clamps the requested sequence length into the legal range.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package seq_pattern_pkg;

    // Two-bit state encoding with fixed values so the register image is stable.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A zero length still plays one step; lengths beyond the table size are
    // limited to the table size.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned depth);
        if (len == 0) begin
            return 1;
        end else if (len > depth) begin
            return depth;
        end else begin
            return len;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_pattern_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : seq_pattern_if
// Purpose  : Control / table-write / step-output bundle of the step-sequence
//            generator.
// Ports    : master - drives wr_en, wr_addr, wr_data, start, stop, pause,
//                     loop_mode, len; observes q, q_valid, idx, busy, done,
//                     wr_err
//            slave  - the sequencer side (directions reversed)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface seq_pattern_if #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = $clog2(DEPTH)
);
    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              stop;
    logic              pause;
    logic              loop_mode;
    logic [IDX_W:0]    len;
    logic [DATA_W-1:0] q;
    logic              q_valid;
    logic [IDX_W-1:0]  idx;
    logic              busy;
    logic              done;
    logic              wr_err;

    modport master (
        output wr_en, wr_addr, wr_data, start, stop, pause, loop_mode, len,
        input  q, q_valid, idx, busy, done, wr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop, pause, loop_mode, len,
        output q, q_valid, idx, busy, done, wr_err
    );
endinterface
`default_nettype wire

// File: rtl/seq_pattern_table.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : seq_pattern_table
// Purpose  : DEPTH x DATA_W pattern register file. Synchronous write,
//            asynchronous read, synchronous clear of every entry on reset.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            we, waddr, wdata  - write port
//            raddr, rdata      - combinational read port
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module seq_pattern_table #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              we,
    input  wire logic [IDX_W-1:0]  waddr,
    input  wire logic [DATA_W-1:0] wdata,
    input  wire logic [IDX_W-1:0]  raddr,
    output logic      [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // DEPTH is a power of two, so every address is a valid entry.
    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/seq_pattern_fsm.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : seq_pattern_fsm
// Purpose  : Programmable step-sequence generator. Plays the first len_q
//            entries of a loadable pattern table, one-shot or looping, with
//            pause and stop control. All outputs come from registers.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous, active-high reset
//            bus  - seq_pattern_if.slave: table write port, start/stop/pause,
//                   loop_mode/len, and q/q_valid/idx/busy/done/wr_err outputs
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module seq_pattern_fsm #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input wire logic     clk,
    input wire logic     rst,
    seq_pattern_if.slave bus
);
    import seq_pattern_pkg::*;

    localparam logic [IDX_W:0]   c_LEN_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_IDX_ZERO = '0;

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_q, w_q_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic              r_q_valid, w_q_valid_nxt;
    logic              r_done, w_done_nxt;
    logic              r_wr_err, w_wr_err_nxt;
    logic [IDX_W:0]    r_len_q, w_len_nxt;
    logic              r_loop_q, w_loop_nxt;

    logic              w_busy;
    logic              w_tab_we;
    logic              w_last;
    logic [IDX_W-1:0]  w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] w_step0_data;

    assign w_busy   = (r_state == RUN) || (r_state == PAUSE);
    assign w_tab_we = bus.wr_en && !w_busy;
    assign w_last   = ({1'b0, r_idx} == (r_len_q - c_LEN_ONE));

    // The single read port always points at the entry the next advance needs:
    // the following step, or entry 0 when wrapping or starting.
    assign w_rd_addr = (w_busy && !w_last) ? (r_idx + c_IDX_ONE) : c_IDX_ZERO;

    // A write to entry 0 in the same cycle as start must be seen at step 0,
    // so forward the write data around the table.
    assign w_step0_data = (w_tab_we && (bus.wr_addr == c_IDX_ZERO)) ?
                          bus.wr_data : w_rd_data;

    seq_pattern_table #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (w_tab_we),
        .waddr (bus.wr_addr),
        .wdata (bus.wr_data),
        .raddr (w_rd_addr),
        .rdata (w_rd_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; stop outranks pause, which outranks step advance.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                w_state_nxt = bus.start ? RUN : IDLE;
            end
            RUN: begin
                if (bus.stop) begin
                    w_state_nxt = IDLE;
                end else if (bus.pause) begin
                    w_state_nxt = PAUSE;
                end else if (w_last && !r_loop_q) begin
                    w_state_nxt = DONE;
                end
            end
            PAUSE: begin
                if (bus.stop) begin
                    w_state_nxt = IDLE;
                end else if (!bus.pause) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Next values for the registered outputs. q and idx hold unless a step
    // advances or a sequence starts.
    always_comb begin
        w_q_nxt       = r_q;
        w_idx_nxt     = r_idx;
        w_q_valid_nxt = 1'b0;
        w_done_nxt    = 1'b0;
        w_len_nxt     = r_len_q;
        w_loop_nxt    = r_loop_q;
        w_wr_err_nxt  = bus.wr_en && w_busy;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_q_nxt       = w_step0_data;
                    w_idx_nxt     = c_IDX_ZERO;
                    w_q_valid_nxt = 1'b1;
                    w_len_nxt     = (IDX_W+1)'(clamp_len(32'(bus.len), DEPTH));
                    w_loop_nxt    = bus.loop_mode;
                end
            end
            RUN: begin
                if (!bus.stop && !bus.pause) begin
                    if (!w_last) begin
                        w_idx_nxt     = r_idx + c_IDX_ONE;
                        w_q_nxt       = w_rd_data;
                        w_q_valid_nxt = 1'b1;
                    end else if (r_loop_q) begin
                        w_idx_nxt     = c_IDX_ZERO;
                        w_q_nxt       = w_rd_data;
                        w_q_valid_nxt = 1'b1;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            PAUSE: begin
                // Leaving pause re-validates the held step; it advances on
                // the following edge.
                if (!bus.stop && !bus.pause) begin
                    w_q_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_q_valid_nxt = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= '0;
            r_idx     <= '0;
            r_q_valid <= 1'b0;
            r_done    <= 1'b0;
            r_wr_err  <= 1'b0;
            r_len_q   <= '0;
            r_loop_q  <= 1'b0;
        end else begin
            r_q       <= w_q_nxt;
            r_idx     <= w_idx_nxt;
            r_q_valid <= w_q_valid_nxt;
            r_done    <= w_done_nxt;
            r_wr_err  <= w_wr_err_nxt;
            r_len_q   <= w_len_nxt;
            r_loop_q  <= w_loop_nxt;
        end
    end

    assign bus.q       = r_q;
    assign bus.q_valid = r_q_valid;
    assign bus.idx     = r_idx;
    assign bus.busy    = w_busy;
    assign bus.done    = r_done;
    assign bus.wr_err  = r_wr_err;

endmodule
`default_nettype wire
